// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a synchronous FIFO with 1-cycle read latency into a
// 2-entry skid buffer and frames the words into BURST_LEN-beat bursts on a
// valid/ready stream. m_sop/m_eop mark the first/last beat of every burst.
// Optional feature macro: FRAMER_TIMEOUT_EN (idle counter driving stall_timeout).
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [15:0]           words_sent,
    output logic                  stall_timeout
);

    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    // Elaboration-time parameter sanity
    if (BURST_LEN < 2) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
    logic [DATA_WIDTH-1:0]   buf0_d;
    logic [1:0]              occ_q, occ_d;
    logic                    inflight_q;
    logic                    rd_d2_q;
    logic [IDX_W-1:0]        beat_idx_q, beat_idx_d;
    logic                    valid_d, sop_d, eop_d;
    logic [15:0]             words_d;

    logic                    pop;
    logic                    cap;
    logic [1:0]              occ_after_pop;
    logic                    credit_ok;
    logic                    settle_ok;

    // Read request: combinational because full throughput needs the credit to
    // see this cycle's pop; the slot freed by the pop is the one the read refills.
    always_comb begin
        pop           = m_valid & m_ready;
        cap           = inflight_q;
        occ_after_pop = occ_q - 2'(pop);
        credit_ok     = (occ_after_pop + 2'(inflight_q)) < 2'd2;
        settle_ok     = !fifo_almost_empty || !(inflight_q || rd_d2_q);
        fifo_read_en  = !reset && !fifo_empty && credit_ok && settle_ok;
    end

    // Next-state: skid buffer, framing, beat counter and FSM
    always_comb begin
        state_d    = state_q;
        buf0_d     = m_data;
        buf1_d     = buf1_q;
        occ_d      = occ_q + 2'(cap) - 2'(pop);
        beat_idx_d = beat_idx_q;
        words_d    = words_sent;

        case ({cap, pop})
            2'b01: buf0_d = buf1_q;
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = fifo_data;
                else               buf1_d = fifo_data;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end
            end
            default: ;
        endcase

        if (pop) begin
            beat_idx_d = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + IDX_W'(1);
            words_d    = words_sent + 16'(1);
        end

        valid_d = (occ_d != 2'd0);
        sop_d   = valid_d && (beat_idx_d == '0);
        eop_d   = valid_d && (beat_idx_d == LAST_IDX);

        case (state_q)
            S_IDLE: begin
                if (fifo_read_en) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pop && m_eop && (occ_d == 2'd0) && !fifo_read_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            m_data     <= '0;
            buf1_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_d2_q    <= 1'b0;
            beat_idx_q <= '0;
            m_valid    <= 1'b0;
            m_sop      <= 1'b0;
            m_eop      <= 1'b0;
            words_sent <= 16'd0;
        end else begin
            state_q    <= state_d;
            m_data     <= buf0_d;
            buf1_q     <= buf1_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_read_en;
            rd_d2_q    <= inflight_q;
            beat_idx_q <= beat_idx_d;
            m_valid    <= valid_d;
            m_sop      <= sop_d;
            m_eop      <= eop_d;
            words_sent <= words_d;
        end
    end

`ifdef FRAMER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            stall_d;
    logic            idle_cycle;

    // Idle counter: partial burst open with nothing buffered or in flight
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        stall_d    = stall_timeout;
        idle_cycle = (beat_idx_q != '0) && (occ_q == 2'd0) && !inflight_q;
        if (pop) begin
            idle_cnt_d = '0;
            stall_d    = 1'b0;
        end else if (idle_cycle && (idle_cnt_q != TO_MAX)) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
            stall_d    = stall_timeout || (idle_cnt_d == TO_MAX);
        end
    end

    // Idle counter and stall flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q    <= '0;
            stall_timeout <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            stall_timeout <= stall_d;
        end
    end
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed, table-driven bench for fifo_burst_reader with
// a behavioural FIFO (1-cycle read latency) and a stream monitor.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty;
    logic        fifo_almost_empty;
    logic [15:0] fifo_data = 16'h0000;
    logic        fifo_read_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic [15:0] words_sent;
    logic        stall_timeout;

    int checks = 0;
    int errors = 0;

`ifdef FRAMER_TIMEOUT_EN
    localparam int EXP_RISE = 32;
`else
    localparam int EXP_RISE = 0;
`endif

    fifo_burst_reader #(
        .DATA_WIDTH(16), .BURST_LEN(4), .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sop(m_sop), .m_eop(m_eop),
        .words_sent(words_sent), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural FIFO: data appears the cycle after the read request
    logic [15:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int underflows = 0;
    assign fifo_empty        = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) <= 1);

    always @(posedge clk) begin
        if (fifo_read_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                underflows <= underflows + 1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Stream monitor: beat log, occupancy model, hold-while-stalled check
    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } rx_t;
    rx_t rx_q[$];
    int  cyc = 0;
    int  occ_m = 0;
    int  infl_m = 0;
    bit  stalled = 1'b0;
    logic [17:0] held;

    always @(posedge clk) begin
        int pop;
        cyc <= cyc + 1;
        if (reset) begin
            occ_m   = 0;
            infl_m  = 0;
            stalled = 1'b0;
        end else begin
            pop = (m_valid && m_ready) ? 1 : 0;
            check("valid_vs_occupancy", 64'(m_valid), 64'(occ_m > 0));
            if (fifo_read_en)
                check("read_credit_overrun", 64'(occ_m + infl_m - pop > 1), 64'(0));
            if (stalled)
                check("hold_while_stalled", {45'd0, m_valid, m_data, m_sop, m_eop}, {45'd0, 1'b1, held});
            if (pop != 0) rx_q.push_back('{m_data, m_sop, m_eop, cyc});
            occ_m   = occ_m + infl_m - pop;
            infl_m  = fifo_read_en ? 1 : 0;
            stalled = m_valid && !m_ready;
            held    = {m_data, m_sop, m_eop};
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {27'd0, fifo_read_en, m_valid, m_sop, m_eop, stall_timeout, m_data, words_sent}, 64'd0);
        reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_beats(input int n, input bit toggle);
        int guard = 0;
        while (rx_q.size() < n && guard < 200) begin
            @(negedge clk);
            if (toggle) m_ready = ~m_ready;
            guard++;
        end
        check("beats_arrived", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic check_beat(input string name, input int idx, input logic [17:0] exp);
        if (idx < rx_q.size())
            check(name, {46'd0, rx_q[idx].data, rx_q[idx].sop, rx_q[idx].eop}, {46'd0, exp});
        else
            check(name, 64'hDEAD, {46'd0, exp});
    endtask

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        bit          toggle;
        logic [15:0] exp_ws;
    } scen_t;

    initial begin
        beat_t exp_beats [8];
        scen_t scen [2];
        int    r0;
        int    rise;

        exp_beats[0] = '{16'h0001, 1'b1, 1'b0};
        exp_beats[1] = '{16'h0002, 1'b0, 1'b0};
        exp_beats[2] = '{16'h0003, 1'b0, 1'b0};
        exp_beats[3] = '{16'h0004, 1'b0, 1'b1};
        exp_beats[4] = '{16'h0005, 1'b1, 1'b0};
        exp_beats[5] = '{16'h0006, 1'b0, 1'b0};
        exp_beats[6] = '{16'h0007, 1'b0, 1'b0};
        exp_beats[7] = '{16'h0008, 1'b0, 1'b1};
        scen[0] = '{1'b0, 16'd8};
        scen[1] = '{1'b1, 16'd16};

        apply_reset();

        // T1 / T2: 8 preloaded words, continuous then toggling m_ready
        for (int s = 0; s < 2; s++) begin
            rx_q.delete();
            m_ready = 1'b1;
            for (int w = 1; w <= 8; w++) push(16'(w));
            wait_beats(8, scen[s].toggle);
            m_ready = 1'b1;
            for (int i = 0; i < 8; i++)
                check_beat($sformatf("scen%0d_beat%0d", s, i), i,
                           {exp_beats[i].data, exp_beats[i].sop, exp_beats[i].eop});
            if (!scen[s].toggle && rx_q.size() >= 7)
                check("t1_back_to_back", 64'(rx_q[6].cyc - rx_q[0].cyc), 64'd6);
            check($sformatf("scen%0d_words_sent", s), 64'(words_sent), 64'(scen[s].exp_ws));
        end

        // T3: single word with almost_empty set
        rx_q.delete();
        r0 = rd_cnt;
        push(16'h0021);
        repeat (10) @(negedge clk);
        check("t3_read_count", 64'(rd_cnt - r0), 64'd1);
        check("t3_beat_count", 64'(rx_q.size()), 64'd1);
        check_beat("t3_beat", 0, {16'h0021, 1'b1, 1'b0});

        // T4: 6 words, pause, then 2 more complete the burst
        apply_reset();
        m_ready = 1'b1;
        for (int w = 0; w < 6; w++) push(16'h0031 + 16'(w));
        wait_beats(6, 1'b0);
        check_beat("t4_beat5", 4, {16'h0035, 1'b1, 1'b0});
        check_beat("t4_beat6", 5, {16'h0036, 1'b0, 1'b0});
        repeat (10) @(negedge clk);
        check("t4_no_extra", {31'd0, m_valid, 32'(rx_q.size())}, {31'd0, 1'b0, 32'd6});
        push(16'h0037);
        push(16'h0038);
        wait_beats(8, 1'b0);
        check_beat("t4_beat7", 6, {16'h0037, 1'b0, 1'b0});
        check_beat("t4_beat8", 7, {16'h0038, 1'b0, 1'b1});
        check("t4_words_sent", 64'(words_sent), 64'd8);

        // T5: reset with beat_idx=2 and both skid entries full
        apply_reset();
        m_ready = 1'b0;
        for (int w = 0; w < 8; w++) push(16'h0041 + 16'(w));
        repeat (6) @(negedge clk);
        check("t5_full_head", {46'd0, m_valid, m_data, m_sop}, {46'd0, 1'b1, 16'h0041, 1'b1});
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_two_sent", 64'(rx_q.size()), 64'd2);
        check("t5_stalled_head", {46'd0, m_valid, m_data, m_sop}, {46'd0, 1'b1, 16'h0043, 1'b0});
        apply_reset();
        m_ready = 1'b1;
        wait_beats(4, 1'b0);
        check_beat("t5_after_reset0", 0, {16'h0045, 1'b1, 1'b0});
        check_beat("t5_after_reset3", 3, {16'h0048, 1'b0, 1'b1});

        // T6: partial burst left idle, then one more beat
        apply_reset();
        m_ready = 1'b1;
        push(16'h0061);
        push(16'h0062);
        wait_beats(2, 1'b0);
        rise = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall_timeout && rise == 0) rise = k;
        end
        check("t6_stall_rise_cycle", 64'(rise), 64'(EXP_RISE));
        push(16'h0063);
        wait_beats(3, 1'b0);
        check_beat("t6_beat3", 2, {16'h0063, 1'b0, 1'b0});
        check("t6_stall_cleared", 64'(stall_timeout), 64'd0);

        check("fifo_underflows", 64'(underflows), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
